vm_proj_mem_writer: RTL

Sequencer that drains one event's projections from the per-sector projection memory and routes each one into one of three virtual-module (VM) projection memories. It replaces the fixed-zero addressing of the VM projection routing stage with real read and write address generation. It sits between the projection memory (upstream, read port) and the three VM projection memories (downstream, write ports). Write addresses are banked by event, so the downstream match engine can read event n while event n+1 is written.

---
 rtl/vm_proj_mem_writer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vm_proj_mem_writer.sv
// Drains one event's projections from the projection memory and routes each into one of three
// VM projection memories, with per-event banked write addressing.
module vm_proj_mem_writer #(
  parameter int unsigned ZBIT    = 29,
  parameter int unsigned NBANK_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [6:0]           number_in,
  input  logic [53:0]          projection,
  output logic [NBANK_W+5:0]   read_projection,
  output logic                 wr_en_1,
  output logic                 wr_en_2,
  output logic                 wr_en_3,
  output logic [NBANK_W+5:0]   wr_add_1,
  output logic [NBANK_W+5:0]   wr_add_2,
  output logic [NBANK_W+5:0]   wr_add_3,
  output logic [12:0]          vm_projection,
  output logic [6:0]           nproj_1,
  output logic [6:0]           nproj_2,
  output logic [6:0]           nproj_3,
  output logic [2:0]           overflow,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [NBANK_W-1:0]          bank_q, bank_d;
  logic [6:0]                  n_q, n_d;
  logic [6:0]                  idx_q, idx_d;
  logic [NBANK_W+5:0]          rd_addr_q, rd_addr_d;
  logic                        v1_q, v1_d, last1_q, last1_d;
  logic                        v2_q, v2_d, last2_q, last2_d;
  logic [5:0]                  idx1_q, idx1_d, idx2_q, idx2_d;
  logic [2:0]                  wr_en_q, wr_en_d;
  logic [2:0][NBANK_W+5:0]     wr_add_q, wr_add_d;
  logic [12:0]                 vm_proj_q, vm_proj_d;
  logic [2:0][6:0]             nproj_q, nproj_d;
  logic [2:0]                  ovf_q, ovf_d;
  logic                        done_q, done_d, busy_q, busy_d;
  logic [2:0]                  sel;
  logic                        route;
  logic [1:0]                  vm;
  logic                        unused_proj;

  // Only a few projection fields are forwarded; the rest of the word is ignored.
  assign unused_proj = ^projection;

  // Address sequencer plus the valid/index/last pipeline that follows each read to its data.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    n_d       = n_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    v1_d      = 1'b0;
    last1_d   = 1'b0;
    idx1_d    = idx1_q;
    v2_d      = v1_q;
    last2_d   = last1_q;
    idx2_d    = idx1_q;
    if (start) begin
      bank_d = bank_q + 1'b1;
      n_d    = (number_in > 7'd64) ? 7'd64 : number_in;
      v2_d   = 1'b0;
      if (n_d == 7'd0) begin
        // Empty event: inject a bare 'last' marker so done lands two cycles out.
        state_d = StDrain;
        last2_d = 1'b1;
        idx_d   = 7'd0;
      end else begin
        state_d   = StRead;
        rd_addr_d = {bank_d, 6'd0};
        v1_d      = 1'b1;
        idx1_d    = 6'd0;
        last1_d   = (n_d == 7'd1);
        last2_d   = 1'b0;
        idx_d     = 7'd1;
      end
    end else begin
      case (state_q)
        StRead: begin
          if (idx_q < n_q) begin
            rd_addr_d = {bank_q, idx_q[5:0]};
            v1_d      = 1'b1;
            idx1_d    = idx_q[5:0];
            last1_d   = (idx_q == n_q - 7'd1);
            idx_d     = idx_q + 7'd1;
          end
          if (idx_q + 7'd1 >= n_q) state_d = StDrain;
        end
        StDrain: state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  // Router: decode the VM selector and build the registered write.
  always_comb begin
    sel   = projection[43:41];
    route = 1'b1;
    vm    = 2'd0;
    case (sel)
      3'd1, 3'd2: vm = 2'd0;
      3'd3, 3'd4: vm = 2'd1;
      3'd5, 3'd6: vm = 2'd2;
      default:    route = 1'b0;
    endcase
    wr_en_d   = 3'b000;
    wr_add_d  = wr_add_q;
    vm_proj_d = vm_proj_q;
    nproj_d   = nproj_q;
    ovf_d     = ovf_q;
    if (v2_q && route) begin
      if (nproj_q[vm] == 7'd64) begin
        ovf_d[vm] = 1'b1;
      end else begin
        wr_en_d[vm]  = 1'b1;
        wr_add_d[vm] = {bank_q, nproj_q[vm][5:0]};
        nproj_d[vm]  = nproj_q[vm] + 7'd1;
        vm_proj_d    = {idx2_q, projection[40:38], projection[ZBIT-3 -: 4]};
      end
    end
    // A new event restarts the counts; a write retiring on this edge still uses the old bank.
    if (start) begin
      nproj_d = '0;
      ovf_d   = 3'b000;
    end
    done_d = last2_q;
    busy_d = start ? 1'b1 : (done_q ? 1'b0 : busy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bank_q    <= '1;
      n_q       <= 7'd0;
      idx_q     <= 7'd0;
      rd_addr_q <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      idx1_q    <= 6'd0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      idx2_q    <= 6'd0;
      wr_en_q   <= 3'b000;
      wr_add_q  <= '0;
      vm_proj_q <= 13'd0;
      nproj_q   <= '0;
      ovf_q     <= 3'b000;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      idx1_q    <= idx1_d;
      v2_q      <= v2_d;
      last2_q   <= last2_d;
      idx2_q    <= idx2_d;
      wr_en_q   <= wr_en_d;
      wr_add_q  <= wr_add_d;
      vm_proj_q <= vm_proj_d;
      nproj_q   <= nproj_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign read_projection = rd_addr_q;
  assign wr_en_1         = wr_en_q[0];
  assign wr_en_2         = wr_en_q[1];
  assign wr_en_3         = wr_en_q[2];
  assign wr_add_1        = wr_add_q[0];
  assign wr_add_2        = wr_add_q[1];
  assign wr_add_3        = wr_add_q[2];
  assign vm_projection   = vm_proj_q;
  assign nproj_1         = nproj_q[0];
  assign nproj_2         = nproj_q[1];
  assign nproj_3         = nproj_q[2];
  assign overflow        = ovf_q;
  assign done            = done_q;
  assign busy            = busy_q;

endmodule
